// File: rtl/sumres3_core.sv
// sumres3_core: two-stage add/subtract of three 4-bit unsigned operands.
// Stage 1 forms a +/- b, and stage 2 forms S1 +/- c. Both results and their
// carry/borrow flags are registered together, so results appear one cycle
// after their inputs.
//
// Interface timing: there is no valid/ready handshake. A new operand set
// (a, b, c, sub) is taken on every rising clk edge. The matching result is
// visible on S1/S2/Cout after that same edge, and it stays there until the
// next edge.
module sumres3_core (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] c,
    input  logic       sub,
    output logic [5:0] S1,
    output logic [5:0] S2,
    output logic [1:0] Cout
);

    // Operands are zero-extended to the 6-bit result width.
    logic [5:0] a_ext;
    logic [5:0] b_ext;
    logic [5:0] c_ext;

    // Second adder operands: inverted when subtracting; the +1 comes from carry-in.
    logic [5:0] b_opnd;
    logic [5:0] c_opnd;

    // 7-bit sums keep the carry out of each 6-bit adder chain.
    logic [6:0] sum1_full;
    logic [6:0] sum2_full;

    logic [5:0] sum1;
    logic [5:0] sum2;
    logic       flag1;
    logic       flag2;

    // Combinational datapath: one shared adder chain per stage, with carry-in = sub.
    always_comb begin
        a_ext  = {2'b00, a};
        b_ext  = {2'b00, b};
        c_ext  = {2'b00, c};
        b_opnd = b_ext ^ {6{sub}};
        c_opnd = c_ext ^ {6{sub}};

        sum1_full = {1'b0, a_ext} + {1'b0, b_opnd} + {6'b000000, sub};
        sum1      = sum1_full[5:0];

        // Stage 2 builds on the 6-bit stage-1 sum.
        sum2_full = {1'b0, sum1} + {1'b0, c_opnd} + {6'b000000, sub};
        sum2      = sum2_full[5:0];

        if (sub) begin
            // In a + ~b + 1, a missing carry out of bit 5 means a < b.
            flag1 = ~sum1_full[6];
            // If a < b, then a < b + c regardless of c. The stage-1 sum is
            // wrapped (49..63) in that case, so the stage-2 carry is
            // meaningless. Otherwise, a missing stage-2 carry means a - b < c.
            flag2 = flag1 | ~sum2_full[6];
        end else begin
            // Sums never reach 64, so any bit above bit 3 means the sum exceeds 15.
            flag1 = |sum1[5:4];
            flag2 = |sum2[5:4];
        end
    end

    // Output register: reset wins; otherwise capture both results and flags together.
    always_ff @(posedge clk) begin
        if (rst) begin
            S1   <= 6'd0;
            S2   <= 6'd0;
            Cout <= 2'b00;
        end else begin
            S1   <= sum1;
            S2   <= sum2;
            Cout <= {flag2, flag1};
        end
    end

endmodule

// File: tb/tb_sumres3_core.sv
// tb_sumres3_core: directed vectors with hand-computed results for sumres3_core.
module tb_sumres3_core;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] c;
  logic       sub;
  logic [5:0] S1;
  logic [5:0] S2;
  logic [1:0] Cout;

  int n_checks = 0;
  int n_errors = 0;

  sumres3_core dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .c    (c),
    .sub  (sub),
    .S1   (S1),
    .S2   (S2),
    .Cout (Cout)
  );

  // Clock and reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one operand set, clock it in, then check the registered result
  // 1 time unit after the edge.
  task automatic run_vec(input string tag, input logic r,
                         input logic [3:0] va, input logic [3:0] vb,
                         input logic [3:0] vc, input logic vs,
                         input logic [5:0] e_s1, input logic [5:0] e_s2,
                         input logic [1:0] e_cout);
    rst = r;
    a   = va;
    b   = vb;
    c   = vc;
    sub = vs;
    @(posedge clk);
    #1;
    check({tag, ".S1"},   {2'b00, S1},     {2'b00, e_s1});
    check({tag, ".S2"},   {2'b00, S2},     {2'b00, e_s2});
    check({tag, ".Cout"}, {6'b000000, Cout}, {6'b000000, e_cout});
  endtask

  initial begin
    rst = 1'b1;
    a   = 4'd5;
    b   = 4'd6;
    c   = 4'd7;
    sub = 1'b0;
    #2;

    // Reset state.
    run_vec("reset",     1'b1, 4'd5,  4'd6,  4'd7,  1'b0, 6'd0,  6'd0,  2'b00);

    // First capture after reset.
    run_vec("first",     1'b0, 4'd0,  4'd1,  4'd0,  1'b0, 6'd1,  6'd1,  2'b00);

    // Addition.
    run_vec("add_7_8_7", 1'b0, 4'd7,  4'd8,  4'd7,  1'b0, 6'd15, 6'd22, 2'b10);
    run_vec("add_14",    1'b0, 4'd14, 4'd15, 4'd14, 1'b0, 6'd29, 6'd43, 2'b11);
    run_vec("add_max",   1'b0, 4'd15, 4'd15, 4'd15, 1'b0, 6'd30, 6'd45, 2'b11);
    run_vec("add_16",    1'b0, 4'd8,  4'd8,  4'd0,  1'b0, 6'd16, 6'd16, 2'b11);
    run_vec("add_15_16", 1'b0, 4'd15, 4'd0,  4'd1,  1'b0, 6'd15, 6'd16, 2'b10);

    // Subtraction.
    run_vec("sub_9_1_2", 1'b1 ^ 1'b1, 4'd9, 4'd1, 4'd2, 1'b1, 6'd8, 6'd6, 2'b00);
    run_vec("sub_13",    1'b0, 4'd13, 4'd5,  4'd6,  1'b1, 6'd8,  6'd2,  2'b00);
    run_vec("sub_neg",   1'b0, 4'd2,  4'd5,  4'd4,  1'b1, 6'd61, 6'd57, 2'b11);
    run_vec("sub_zero",  1'b0, 4'd5,  4'd5,  4'd0,  1'b1, 6'd0,  6'd0,  2'b00);
    run_vec("sub_eq_c",  1'b0, 4'd5,  4'd3,  4'd2,  1'b1, 6'd2,  6'd0,  2'b00);
    run_vec("sub_m1",    1'b0, 4'd5,  4'd3,  4'd3,  1'b1, 6'd2,  6'd63, 2'b10);
    run_vec("sub_big",   1'b0, 4'd0,  4'd15, 4'd15, 1'b1, 6'd49, 6'd34, 2'b11);

    // Back-to-back operand sets with alternating sub.
    run_vec("alt0",      1'b0, 4'd3,  4'd4,  4'd5,  1'b0, 6'd7,  6'd12, 2'b00);
    run_vec("alt1",      1'b0, 4'd3,  4'd4,  4'd5,  1'b1, 6'd63, 6'd58, 2'b11);
    run_vec("alt2",      1'b0, 4'd10, 4'd6,  4'd0,  1'b0, 6'd16, 6'd16, 2'b11);
    run_vec("alt3",      1'b0, 4'd10, 4'd6,  4'd0,  1'b1, 6'd4,  6'd4,  2'b00);

    // Outputs hold between edges.
    #3;
    check("hold.S1",   {2'b00, S1},       8'd4);
    check("hold.S2",   {2'b00, S2},       8'd4);
    check("hold.Cout", {6'b000000, Cout}, 8'd0);

    // Reset in mid-stream while inputs keep changing, then resume capture.
    run_vec("pre_rst",   1'b0, 4'd12, 4'd9,  4'd1,  1'b0, 6'd21, 6'd22, 2'b11);
    run_vec("mid_rst",   1'b1, 4'd1,  4'd2,  4'd3,  1'b0, 6'd0,  6'd0,  2'b00);
    run_vec("post_rst",  1'b0, 4'd4,  4'd4,  4'd4,  1'b0, 6'd8,  6'd12, 2'b00);
    run_vec("post_rst2", 1'b0, 4'd1,  4'd2,  4'd3,  1'b1, 6'd63, 6'd60, 2'b11);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sumres3_core.md
SUMRES3_CORE -- requirements
Module: sumres3

Interface
REQ-001 clk  input  1  single clock; all state updates on its rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 a  input  4  unsigned operand A.
REQ-004 b  input  4  unsigned operand B.
REQ-005 c  input  4  unsigned operand C.
REQ-006 sub  input  1  mode select: 0 = add, 1 = subtract.
REQ-007 S1  output  6  registered first-stage result, a +/- b, 6-bit two's complement.
REQ-008 S2  output  6  registered second-stage result, S1 +/- c, 6-bit two's complement.
REQ-009 Cout  output  2  registered status; bit0 = stage-1 carry/borrow, bit1 = stage-2 carry/borrow.

Function
REQ-010 The block SHALL zero-extend a, b and c to 6 bits before any arithmetic.
REQ-011 With sub=0 the block SHALL compute S1 = a+b and S2 = a+b+c, modulo 64.
REQ-012 With sub=1 the block SHALL compute S1 = a-b and S2 = a-b-c, modulo 64, so negative results appear in two's complement (e.g. -3 = 61).
REQ-013 Subtraction SHALL be implemented as addition of the bitwise-inverted operand with carry-in = sub, using one shared adder chain per stage.
REQ-014 Stage 2 SHALL take the 6-bit stage-1 sum as its first operand.
REQ-015 Cout[0] SHALL be 1 when sub=0 and a+b > 15, or when sub=1 and a < b; otherwise 0.
REQ-016 Cout[1] SHALL be 1 when sub=0 and a+b+c > 15, or when sub=1 and a < b+c; otherwise 0.
REQ-017 S1, S2 and Cout SHALL be captured together on the same rising clk edge.
REQ-018 Latency from input sampling to output SHALL be exactly one clock cycle.
REQ-019 A new operand set SHALL be accepted every cycle; there is no handshake and no stall.
REQ-020 sub SHALL be sampled on the same edge as its operands; changing sub between cycles SHALL affect only the result of that cycle.
REQ-021 Outputs SHALL hold their value while rst=0 and no clock edge occurs.
REQ-022 Maximum values SHALL not saturate: a=b=c=15 with sub=0 SHALL give S1=30, S2=45, Cout=2'b11.

Reset
REQ-023 When rst=1 at a rising clk edge, S1, S2 and Cout SHALL all become 0 at that edge.
REQ-024 rst SHALL take priority over input capture on the same edge.
REQ-025 Reset asserted mid-stream SHALL discard the in-flight result.
REQ-026 Capture SHALL resume with the inputs present on the first edge where rst=0.
REQ-027 Output values before the first reset are unspecified.

Verification
REQ-028 rst=1 for one cycle, then a=0, b=1, c=0, sub=0 -> one cycle later S1=1, S2=1, Cout=2'b00.
REQ-029 a=7, b=8, c=7, sub=0 -> S1=15, S2=22, Cout=2'b10; then a=14, b=15, c=14 -> S1=29, S2=43, Cout=2'b11.
REQ-030 sub=1 with a=9, b=1, c=2 -> S1=8, S2=6, Cout=2'b00; then a=13, b=5, c=6 -> S1=8, S2=2, Cout=2'b00.
REQ-031 sub=1 with a=2, b=5, c=4 -> S1=61, S2=57, Cout=2'b11.
REQ-032 Back-to-back inputs on consecutive cycles, alternating sub -> each result appears exactly one cycle after its inputs, with no bubbles.
REQ-033 Assert rst while results are non-zero, with inputs still changing -> outputs are 0 on that edge; the first post-reset result matches the inputs sampled at that edge.
